// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU ops,
// write-data selects, status codes and the sequencer state type.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [2:0] WD_ALU    = 3'd0;
  localparam logic [2:0] WD_DMEM   = 3'd1;
  localparam logic [2:0] WD_PC1    = 3'd2;
  localparam logic [2:0] WD_SETX   = 3'd3;
  localparam logic [2:0] WD_STATUS = 3'd4;
  localparam logic [2:0] WD_MD     = 3'd5;

  localparam logic [2:0] ST_NONE       = 3'd0;
  localparam logic [2:0] ST_ADD_OVF    = 3'd1;
  localparam logic [2:0] ST_ADDI_OVF   = 3'd2;
  localparam logic [2:0] ST_SUB_OVF    = 3'd3;
  localparam logic [2:0] ST_MUL_EXC    = 3'd4;
  localparam logic [2:0] ST_DIV_EXC    = 3'd5;
  localparam logic [2:0] ST_MD_TIMEOUT = 3'd6;

  typedef enum logic [0:0] {
    EXEC = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode/flag decode; knows nothing about instr_valid
// or the mul/div sequencing, which the top layers on.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31
) (
  input  logic [31:0] instr,
  input  logic        isNotEqual,
  input  logic        isLessThan,
  input  logic        overflow,
  output logic        rwe,
  output logic [4:0]  rd_sel,
  output logic        rs_sel_rd,
  output logic        rs_zero,
  output logic        alu_inb_imm,
  output logic [4:0]  alu_op,
  output logic        dmwe,
  output logic        br,
  output logic        jp,
  output logic        jr,
  output logic [2:0]  wd_sel,
  output logic [2:0]  status_code,
  output logic        is_mul,
  output logic        is_div
);

  logic [4:0] opcode;
  logic [4:0] rd;
  logic [4:0] fn;
  logic       we;
  logic       forced_we;
  logic       unused_bits;

  assign opcode      = instr[31:27];
  assign rd          = instr[26:22];
  assign fn          = instr[6:2];
  assign unused_bits = ^{instr[21:7], instr[1:0]};

  always_comb begin
    we          = 1'b0;
    forced_we   = 1'b0;
    rd_sel      = rd;
    rs_sel_rd   = 1'b0;
    rs_zero     = 1'b0;
    alu_inb_imm = 1'b0;
    alu_op      = ALU_ADD;
    dmwe        = 1'b0;
    br          = 1'b0;
    jp          = 1'b0;
    jr          = 1'b0;
    wd_sel      = WD_ALU;
    status_code = ST_NONE;
    is_mul      = 1'b0;
    is_div      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_op = fn;
        we     = 1'b1;
        if (fn == ALU_MUL) begin
          is_mul = 1'b1;
        end else if (fn == ALU_DIV) begin
          is_div = 1'b1;
        end else if (overflow && (fn == ALU_ADD || fn == ALU_SUB)) begin
          forced_we   = 1'b1;
          rd_sel      = 5'(STATUS_REG);
          wd_sel      = WD_STATUS;
          status_code = (fn == ALU_ADD) ? ST_ADD_OVF : ST_SUB_OVF;
        end
      end
      OP_J: jp = 1'b1;
      OP_BNE: begin
        rs_sel_rd = 1'b1;
        alu_op    = ALU_SUB;
        br        = isNotEqual;
      end
      OP_JAL: begin
        jp        = 1'b1;
        we        = 1'b1;
        forced_we = 1'b1;
        rd_sel    = 5'(LINK_REG);
        wd_sel    = WD_PC1;
      end
      OP_JR: begin
        jr        = 1'b1;
        rs_sel_rd = 1'b1;
      end
      OP_ADDI: begin
        alu_inb_imm = 1'b1;
        we          = 1'b1;
        if (overflow) begin
          forced_we   = 1'b1;
          rd_sel      = 5'(STATUS_REG);
          wd_sel      = WD_STATUS;
          status_code = ST_ADDI_OVF;
        end
      end
      OP_BLT: begin
        rs_sel_rd = 1'b1;
        alu_op    = ALU_SUB;
        br        = isNotEqual & ~isLessThan;
      end
      OP_SW: begin
        alu_inb_imm = 1'b1;
        rs_sel_rd   = 1'b1;
        dmwe        = 1'b1;
      end
      OP_LW: begin
        alu_inb_imm = 1'b1;
        we          = 1'b1;
        wd_sel      = WD_DMEM;
      end
      OP_SETX: begin
        we        = 1'b1;
        forced_we = 1'b1;
        rd_sel    = 5'(STATUS_REG);
        wd_sel    = WD_SETX;
      end
      OP_BEX: begin
        rs_zero   = 1'b1;
        rs_sel_rd = 1'b1;
        alu_op    = ALU_SUB;
        jp        = isNotEqual;
      end
      default: ;
    endcase
  end

  // r0 is never written by ordinary results; status and link writes always go through.
  assign rwe = we & (forced_we | (rd_sel != 5'd0));

endmodule

// File: rtl/multicycle_control_unit.sv
// Instruction sequencer: single-cycle decode plus a stalled mul/div handshake
// with exception reporting and a timeout watchdog.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31,
  parameter int MD_TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  input  logic                  isNotEqual,
  input  logic                  isLessThan,
  input  logic                  overflow,
  input  logic                  md_ready,
  input  logic                  md_exception,
  output logic                  pc_en,
  output logic                  rwe,
  output logic [4:0]            rd_sel,
  output logic                  rs_sel_rd,
  output logic                  rs_zero,
  output logic                  alu_inb_imm,
  output logic [4:0]            alu_op,
  output logic                  dmwe,
  output logic                  br,
  output logic                  jp,
  output logic                  jr,
  output logic [2:0]            wd_sel,
  output logic                  md_start_mult,
  output logic                  md_start_div,
  output logic [DATA_WIDTH-1:0] status_val,
  output logic                  busy
);

  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       lat_rd;
  logic             lat_div;

  logic       d_rwe, d_rs_sel_rd, d_rs_zero, d_imm, d_dmwe, d_br, d_jp, d_jr;
  logic       d_is_mul, d_is_div;
  logic [4:0] d_rd_sel, d_alu_op;
  logic [2:0] d_wd_sel, d_status;
  logic [2:0] status_code;
  logic       md_launch;

  instr_decoder #(
    .STATUS_REG(STATUS_REG),
    .LINK_REG  (LINK_REG)
  ) u_dec (
    .instr      (instr),
    .isNotEqual (isNotEqual),
    .isLessThan (isLessThan),
    .overflow   (overflow),
    .rwe        (d_rwe),
    .rd_sel     (d_rd_sel),
    .rs_sel_rd  (d_rs_sel_rd),
    .rs_zero    (d_rs_zero),
    .alu_inb_imm(d_imm),
    .alu_op     (d_alu_op),
    .dmwe       (d_dmwe),
    .br         (d_br),
    .jp         (d_jp),
    .jr         (d_jr),
    .wd_sel     (d_wd_sel),
    .status_code(d_status),
    .is_mul     (d_is_mul),
    .is_div     (d_is_div)
  );

  assign md_launch = (state == EXEC) && instr_valid && (d_is_mul || d_is_div);

  always_comb begin
    pc_en         = 1'b0;
    rwe           = 1'b0;
    rd_sel        = d_rd_sel;
    rs_sel_rd     = 1'b0;
    rs_zero       = 1'b0;
    alu_inb_imm   = 1'b0;
    alu_op        = ALU_ADD;
    dmwe          = 1'b0;
    br            = 1'b0;
    jp            = 1'b0;
    jr            = 1'b0;
    wd_sel        = d_wd_sel;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    status_code   = ST_NONE;
    busy          = (state != EXEC);
    if (state == EXEC) begin
      rs_sel_rd   = d_rs_sel_rd;
      rs_zero     = d_rs_zero;
      alu_inb_imm = d_imm;
      alu_op      = d_alu_op;
      if (md_launch) begin
        md_start_mult = d_is_mul;
        md_start_div  = d_is_div;
      end else if (instr_valid) begin
        pc_en       = 1'b1;
        rwe         = d_rwe;
        dmwe        = d_dmwe;
        br          = d_br;
        jp          = d_jp;
        jr          = d_jr;
        status_code = d_status;
      end
    end else begin
      rd_sel = lat_rd;
      wd_sel = WD_MD;
      // A ready in the final watchdog cycle still counts as a normal completion.
      if (md_ready) begin
        pc_en = 1'b1;
        if (md_exception) begin
          rwe         = 1'b1;
          rd_sel      = 5'(STATUS_REG);
          wd_sel      = WD_STATUS;
          status_code = lat_div ? ST_DIV_EXC : ST_MUL_EXC;
        end else begin
          rwe = (lat_rd != 5'd0);
        end
      end else if (cnt == CNT_LAST) begin
        pc_en       = 1'b1;
        rwe         = 1'b1;
        rd_sel      = 5'(STATUS_REG);
        wd_sel      = WD_STATUS;
        status_code = ST_MD_TIMEOUT;
      end
    end
    if (!reset_n) begin
      pc_en         = 1'b0;
      rwe           = 1'b0;
      dmwe          = 1'b0;
      br            = 1'b0;
      jp            = 1'b0;
      jr            = 1'b0;
      md_start_mult = 1'b0;
      md_start_div  = 1'b0;
    end
  end

  assign status_val = DATA_WIDTH'(status_code);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EXEC;
      cnt     <= '0;
      lat_rd  <= 5'd0;
      lat_div <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (md_launch) begin
            state   <= WAIT;
            cnt     <= '0;
            lat_rd  <= instr[26:22];
            lat_div <= d_is_div;
          end
        end
        WAIT: begin
          if (md_ready || cnt == CNT_LAST) begin
            state <= EXEC;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= EXEC;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised bench for multicycle_control_unit against a cycle-level
// reference model of pending mul/div operations and per-opcode decode tables.
module tb_multicycle_control_unit;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_valid = 1'b0;
  logic        isNotEqual = 1'b0;
  logic        isLessThan = 1'b0;
  logic        overflow = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        pc_en, rwe, rs_sel_rd, rs_zero, alu_inb_imm, dmwe, br, jp, jr;
  logic        md_start_mult, md_start_div, busy;
  logic [4:0]  rd_sel, alu_op;
  logic [2:0]  wd_sel;
  logic [31:0] status_val;

  int total = 0;
  int bad = 0;

  // Reference model state: an outstanding mul/div and how long it has waited.
  bit       m_pend = 1'b0;
  bit       m_div = 1'b0;
  bit [4:0] m_rd = 5'd0;
  int       m_el = 0;

  typedef struct packed {
    bit       full;
    bit       pc_en;
    bit       rwe;
    bit [4:0] rd_sel;
    bit       rs_sel_rd;
    bit       rs_zero;
    bit       imm;
    bit [4:0] alu_op;
    bit       dmwe;
    bit       br;
    bit       jp;
    bit       jr;
    bit [2:0] wd_sel;
    bit       sm;
    bit       sd;
    bit [31:0] sv;
    bit       busy;
  } exp_t;

  logic [4:0] ops [14] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
                           5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd0};

  multicycle_control_unit #(
    .DATA_WIDTH(32),
    .STATUS_REG(30),
    .LINK_REG  (31),
    .MD_TIMEOUT(TMO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .isNotEqual   (isNotEqual),
    .isLessThan   (isLessThan),
    .overflow     (overflow),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .pc_en        (pc_en),
    .rwe          (rwe),
    .rd_sel       (rd_sel),
    .rs_sel_rd    (rs_sel_rd),
    .rs_zero      (rs_zero),
    .alu_inb_imm  (alu_inb_imm),
    .alu_op       (alu_op),
    .dmwe         (dmwe),
    .br           (br),
    .jp           (jp),
    .jr           (jr),
    .wd_sel       (wd_sel),
    .md_start_mult(md_start_mult),
    .md_start_div (md_start_div),
    .status_val   (status_val),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] fn);
    return {5'd0, rd, 5'd1, 5'd2, 5'd0, fn, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 5'd1, 17'h00123};
  endfunction

  function automatic exp_t status_write(input exp_t e0, input int code);
    exp_t e = e0;
    e.rwe = 1'b1;
    e.rd_sel = 5'd30;
    e.wd_sel = 3'd4;
    e.sv = 32'(code);
    return e;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [4:0] op, rd, fn;
    e = '0;
    op = instr[31:27];
    rd = instr[26:22];
    fn = instr[6:2];
    if (m_pend) begin
      e.busy = 1'b1;
      if (md_ready) begin
        e.pc_en = 1'b1;
        if (md_exception) e = status_write(e, m_div ? 5 : 4);
        else begin
          e.rwe = (m_rd != 5'd0);
          e.rd_sel = m_rd;
          e.wd_sel = 3'd5;
        end
      end else if (m_el == TMO - 1) begin
        e.pc_en = 1'b1;
        e = status_write(e, 6);
      end
      return e;
    end
    if (!instr_valid) return e;
    e.full = 1'b1;
    e.pc_en = 1'b1;
    case (op)
      5'd0: begin
        e.alu_op = fn;
        if (fn == 5'd6 || fn == 5'd7) begin
          e.pc_en = 1'b0;
          e.sm = (fn == 5'd6);
          e.sd = (fn == 5'd7);
        end else if (overflow && (fn == 5'd0 || fn == 5'd1)) begin
          e = status_write(e, (fn == 5'd0) ? 1 : 3);
        end else begin
          e.rwe = (rd != 5'd0);
          e.rd_sel = rd;
        end
      end
      5'd1: e.jp = 1'b1;
      5'd2: begin e.rs_sel_rd = 1'b1; e.alu_op = 5'd1; e.br = isNotEqual; end
      5'd3: begin e.jp = 1'b1; e.rwe = 1'b1; e.rd_sel = 5'd31; e.wd_sel = 3'd2; end
      5'd4: begin e.jr = 1'b1; e.rs_sel_rd = 1'b1; end
      5'd5: begin
        e.imm = 1'b1;
        if (overflow) e = status_write(e, 2);
        else begin e.rwe = (rd != 5'd0); e.rd_sel = rd; end
      end
      5'd6: begin e.rs_sel_rd = 1'b1; e.alu_op = 5'd1; e.br = isNotEqual & ~isLessThan; end
      5'd7: begin e.imm = 1'b1; e.dmwe = 1'b1; e.rs_sel_rd = 1'b1; end
      5'd8: begin e.imm = 1'b1; e.wd_sel = 3'd1; e.rwe = (rd != 5'd0); e.rd_sel = rd; end
      5'd21: begin e.rwe = 1'b1; e.rd_sel = 5'd30; e.wd_sel = 3'd3; end
      5'd22: begin e.rs_zero = 1'b1; e.rs_sel_rd = 1'b1; e.alu_op = 5'd1; e.jp = isNotEqual; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_all(input exp_t e);
    chk("pc_en", 32'(pc_en), 32'(e.pc_en));
    chk("rwe", 32'(rwe), 32'(e.rwe));
    chk("dmwe", 32'(dmwe), 32'(e.dmwe));
    chk("br", 32'(br), 32'(e.br));
    chk("jp", 32'(jp), 32'(e.jp));
    chk("jr", 32'(jr), 32'(e.jr));
    chk("start_mult", 32'(md_start_mult), 32'(e.sm));
    chk("start_div", 32'(md_start_div), 32'(e.sd));
    chk("busy", 32'(busy), 32'(e.busy));
    if (e.rwe) begin
      chk("rd_sel", 32'(rd_sel), 32'(e.rd_sel));
      chk("wd_sel", 32'(wd_sel), 32'(e.wd_sel));
      if (e.wd_sel == 3'd4) chk("status_val", status_val, e.sv);
    end
    if (e.full) begin
      chk("rs_sel_rd", 32'(rs_sel_rd), 32'(e.rs_sel_rd));
      chk("rs_zero", 32'(rs_zero), 32'(e.rs_zero));
      chk("alu_inb_imm", 32'(alu_inb_imm), 32'(e.imm));
      chk("alu_op", 32'(alu_op), 32'(e.alu_op));
    end
  endtask

  task automatic model_update();
    if (m_pend) begin
      if (md_ready || m_el == TMO - 1) m_pend = 1'b0;
      else m_el++;
    end else if (instr_valid && instr[31:27] == 5'd0 &&
                 (instr[6:2] == 5'd6 || instr[6:2] == 5'd7)) begin
      m_pend = 1'b1;
      m_div = (instr[6:2] == 5'd7);
      m_rd = instr[26:22];
      m_el = 0;
    end
  endtask

  task automatic step(input logic [31:0] i, input logic v, input logic ne, input logic lt,
                      input logic ov, input logic rdy, input logic ex);
    @(posedge clock);
    #1;
    instr = i;
    instr_valid = v;
    isNotEqual = ne;
    isLessThan = lt;
    overflow = ov;
    md_ready = rdy;
    md_exception = ex;
    #3;
    check_all(predict());
    model_update();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    chk({tag, "_rwe"}, 32'(rwe), 32'd0);
    chk({tag, "_dmwe"}, 32'(dmwe), 32'd0);
    chk({tag, "_br"}, 32'(br), 32'd0);
    chk({tag, "_jp"}, 32'(jp), 32'd0);
    chk({tag, "_jr"}, 32'(jr), 32'd0);
    chk({tag, "_start_mult"}, 32'(md_start_mult), 32'd0);
    chk({tag, "_start_div"}, 32'(md_start_div), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_random(input int n);
    logic [31:0] i;
    logic [4:0]  op, fn, rd;
    int          k;
    for (int c = 0; c < n; c++) begin
      k = $urandom_range(0, 13);
      op = (k == 13) ? 5'($urandom) : ops[k];
      case ($urandom_range(0, 4))
        0: fn = 5'd0;
        1: fn = 5'd1;
        2: fn = 5'd6;
        3: fn = 5'd7;
        default: fn = 5'($urandom);
      endcase
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      i = {op, rd, 5'($urandom), 10'($urandom), fn, 2'($urandom)};
      step(i, ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0), 1'($urandom));
    end
  endtask

  initial begin
    int stalls;

    // Reset held with a live instruction and a spurious ready on the inputs.
    instr = i_type(5'd8, 5'd4);
    instr_valid = 1'b1;
    md_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // add overflow, then bne taken
    step(r_type(5'd3, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("add_ovf_status", status_val, 32'd1);
    step(i_type(5'd2, 5'd4), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bne_br", 32'(br), 32'd1);

    // mul r5 with ready three cycles after start
    stalls = 0;
    step(r_type(5'd5, 5'd6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!pc_en) stalls++;
    for (int c = 0; c < 2; c++) begin
      step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!pc_en) stalls++;
    end
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mul_stalls", 32'(stalls), 32'd3);
    chk("mul_wb_rd", 32'(rd_sel), 32'd5);

    // div exception
    step(r_type(5'd7, 5'd7), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("div_exc_status", status_val, 32'd5);

    // mul with no ready: watchdog
    stalls = 0;
    step(r_type(5'd6, 5'd6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!pc_en) stalls++;
    for (int c = 0; c < 20; c++) begin
      step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (pc_en) break;
      stalls++;
    end
    chk("timeout_stalls", 32'(stalls), 32'd8);
    chk("timeout_status", status_val, 32'd6);
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_busy_drop", 32'(busy), 32'd0);

    // mul with rd = 0 writes nothing on completion
    step(r_type(5'd0, 5'd6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mul_r0_rwe", 32'(rwe), 32'd0);

    // Reset in the middle of a WAIT with ready pending on the inputs
    step(r_type(5'd9, 5'd6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    instr = r_type(5'd3, 5'd0);
    instr_valid = 1'b1;
    md_ready = 1'b1;
    md_exception = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midwait");
    m_pend = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(r_type(5'd3, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_rd", 32'(rd_sel), 32'd3);

    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
